hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RV32I core.
- Drives the execute stage's ForwardA/ForwardB selects and the Stall/Flush enables of the F/D/E/M pipeline registers.
- Sequences three hazards:
  - load-use stalls
  - taken branch/jump flushes
  - multi-cycle data-memory misses, handled by a two-state FSM
- Keeps saturating performance counters for each hazard class.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/sat_counter.sv | 17 +
 rtl/hazard_ctrl.sv | 78 +++++++
 tb/tb_hazard_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings for the RV32I pipeline hazard logic
package pipe_pkg;
  typedef enum logic [1:0] {
    FWD_RD = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;
  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } hz_state_e;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  function automatic fwd_sel_e fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                       input logic wm, input logic [4:0] rdw, input logic ww);
    fwd_sel = (wm && rdm != 5'd0 && rdm == rs) ? FWD_M :
              (ww && rdw != 5'd0 && rdw == rs) ? FWD_W : FWD_RD;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use/branch/miss stall-flush control and hazard counters
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int         CNT_W    = 32,
  parameter logic [1:0] LOAD_SRC = RESULT_LOAD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MissM,
  input  logic             RefillDone,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [CNT_W-1:0] LoadUseCnt,
  output logic [CNT_W-1:0] MissCnt,
  output logic [CNT_W-1:0] FlushCnt
);
  hz_state_e state_q, state_d;
  logic load_use, lu_hit, br_hit;
  assign ForwardA = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardB = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  assign load_use = (ResultSrcE == LOAD_SRC) && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  // Frozen E/M stages keep their branch/load-use until the first RUN cycle after a refill
  always_comb begin
    state_d = state_q;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    lu_hit  = 1'b0;
    br_hit  = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (state_q == MISS || MissM) begin
      StallF  = 1'b1;
      StallD  = 1'b1;
      StallE  = 1'b1;
      FlushM  = 1'b1;
      state_d = (state_q == MISS) ? (RefillDone ? RUN : MISS) : MISS;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      br_hit = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
      lu_hit = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end
  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (.clk(clk), .rst(rst), .inc_i(lu_hit), .cnt_o(LoadUseCnt));
  sat_counter #(.CNT_W(CNT_W)) u_ms_cnt (.clk(clk), .rst(rst), .inc_i(StallE), .cnt_o(MissCnt));
  sat_counter #(.CNT_W(CNT_W)) u_fl_cnt (.clk(clk), .rst(rst), .inc_i(br_hit), .cnt_o(FlushCnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus against a rule-level model of the hazard controller
module tb_hazard_ctrl;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] Rs1D = 0, Rs2D = 0, Rs1E = 0, Rs2E = 0, RdE = 0, RdM = 0, RdW = 0;
  logic [1:0] ResultSrcE = 0;
  logic RegWriteM = 0, RegWriteW = 0, PCSrcE = 0, MissM = 0, RefillDone = 0;
  logic [1:0] ForwardA, ForwardB;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [CW-1:0] LoadUseCnt, MissCnt, FlushCnt;
  int tests = 0, fails = 0;
  bit m_miss = 0;
  int c_lu = 0, c_ms = 0, c_fl = 0;
  hazard_ctrl #(.CNT_W(CW), .LOAD_SRC(2'b01)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MissM(MissM), .RefillDone(RefillDone),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .LoadUseCnt(LoadUseCnt), .MissCnt(MissCnt), .FlushCnt(FlushCnt)
  );
  always #5 clk = ~clk;
  function automatic int fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2;
    if (RegWriteW && RdW != 0 && RdW == rs) return 1;
    return 0;
  endfunction
  // 0 reset, 1 miss stall, 2 branch flush, 3 load-use stall, 4 quiet
  function automatic int category();
    if (rst) return 0;
    if (m_miss || MissM) return 1;
    if (PCSrcE) return 2;
    if (ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D)) return 3;
    return 4;
  endfunction
  function automatic logic [5:0] ctrl_for(input int cat);
    logic [5:0] tbl [5];
    tbl[0] = 6'b000110; tbl[1] = 6'b111001; tbl[2] = 6'b000110;
    tbl[3] = 6'b110010; tbl[4] = 6'b000000;
    return tbl[cat];
  endfunction
  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction
  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    int cat;
    cat = category();
    if (rst) begin
      m_miss = 0; c_lu = 0; c_ms = 0; c_fl = 0;
    end else begin
      if (cat == 1) c_ms = sat(c_ms + 1);
      if (cat == 2) c_fl = sat(c_fl + 1);
      if (cat == 3) c_lu = sat(c_lu + 1);
      m_miss = m_miss ? !RefillDone : MissM;
    end
  end
  always @(negedge clk) begin
    chk("model_fwdA", int'(ForwardA), fwd(Rs1E));
    chk("model_fwdB", int'(ForwardB), fwd(Rs2E));
    chk("model_ctrl", int'({StallF, StallD, StallE, FlushD, FlushE, FlushM}), int'(ctrl_for(category())));
    chk("model_lucnt", int'(LoadUseCnt), c_lu);
    chk("model_mscnt", int'(MissCnt), c_ms);
    chk("model_flcnt", int'(FlushCnt), c_fl);
  end
  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic mid();
    @(negedge clk); #1;
  endtask
  task automatic clear();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0; ResultSrcE = 0;
    RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MissM = 0; RefillDone = 0;
  endtask
  initial begin
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
    mid();
    chk("rst_flushD", FlushD, 1); chk("rst_flushE", FlushE, 1);
    chk("rst_stallE", StallE, 0); chk("rst_fwdA", ForwardA, 2);
    cyc(); rst = 0;
    mid(); chk("cnt_zero", LoadUseCnt, 0); chk("fwdA_M", ForwardA, 2);
    cyc(); RegWriteM = 0;
    mid(); chk("fwdA_W", ForwardA, 1); chk("fwdB_W", ForwardB, 1);
    cyc(); Rs1E = 0;
    mid(); chk("fwdA_x0", ForwardA, 0); chk("fwdB_still_W", ForwardB, 1);
    cyc(); clear(); RefillDone = 1;
    mid(); chk("refill_ignored_run", StallE, 0);
    cyc(); clear(); ResultSrcE = 1; RdE = 7; Rs2D = 7;
    mid(); chk("lu_stallF", StallF, 1); chk("lu_stallD", StallD, 1); chk("lu_flushE", FlushE, 1);
    chk("lu_flushD", FlushD, 0);
    cyc(); clear();
    mid(); chk("lu_cnt1", LoadUseCnt, 1); chk("lu_stall_done", StallF, 0);
    cyc(); rst = 1;
    cyc(); rst = 0; ResultSrcE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
    mid(); chk("br_flushD", FlushD, 1); chk("br_flushE", FlushE, 1); chk("br_stallF", StallF, 0);
    cyc(); clear();
    mid(); chk("br_cnt1", FlushCnt, 1); chk("br_lucnt0", LoadUseCnt, 0);
    cyc(); MissM = 1;
    for (int i = 0; i < 5; i++) begin
      mid(); chk("miss_stallE", StallE, 1); chk("miss_flushM", FlushM, 1);
      cyc(); MissM = 0; RefillDone = (i == 3);
    end
    RefillDone = 0;
    mid(); chk("miss_back_run", StallE, 0); chk("miss_cnt5", MissCnt, 5);
    cyc(); MissM = 1; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      mid(); chk("missbr_flushD0", FlushD, 0); chk("missbr_stallE", StallE, 1);
      cyc(); MissM = (i == 0); RefillDone = (i == 1);
    end
    RefillDone = 0; MissM = 0;
    mid(); chk("postmiss_flushD", FlushD, 1); chk("postmiss_flushE", FlushE, 1);
    chk("postmiss_miss8", MissCnt, 8);
    cyc(); clear(); MissM = 1;
    cyc(); MissM = 0;
    cyc(); rst = 1;
    mid(); chk("rst_in_miss_stall", StallF, 0); chk("rst_in_miss_flushM", FlushM, 0);
    cyc(); rst = 0;
    mid(); chk("after_rst_run", StallE, 0); chk("after_rst_mscnt", MissCnt, 0);
    chk("after_rst_flcnt", FlushCnt, 0);
    cyc(); ResultSrcE = 1; RdE = 3; Rs1D = 3;
    repeat (CMAX + 4) cyc();
    mid(); chk("lu_saturated", LoadUseCnt, CMAX);
    cyc(); clear();
    mid(); chk("lu_sat_hold", LoadUseCnt, CMAX);
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
